// File: rtl/register_dump_reader_if.sv
// Bank read port plus outbound byte stream between the dump reader and its
// neighbours. The master side is the reader; the slave side is bank + UART.
interface register_dump_reader_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
);
  logic [NB_REG-1:0]  o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport master (
    output o_rd_addr,
    input  i_rd_data,
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    input  o_rd_addr,
    output i_rd_data,
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );
endinterface

// File: rtl/register_dump_reader.sv
// Register bank dump reader: on i_start walks bank addresses 0..N_WORDS-1,
// latches each word and streams it MSB byte first over a valid/ready byte
// channel. o_busy doubles as the pipeline halt request for the whole dump.
module register_dump_reader #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_WORDS = 2**NB_REG
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  register_dump_reader_if.master io_bus
);

  localparam int unsigned BPW    = NB_DATA / 8;
  localparam int unsigned NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [NB_CNT-1:0] LastByte = NB_CNT'(BPW - 1);
  localparam logic [NB_REG-1:0] LastAddr = NB_REG'(N_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [NB_REG-1:0]   r_addr, w_addr_nxt;
  logic [NB_DATA-1:0]  r_shreg, w_shreg_nxt;
  logic [NB_CNT-1:0]   r_byte_cnt, w_byte_cnt_nxt;

  // State and datapath registers; reset overrides any handshake in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_shreg    <= w_shreg_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // Next-state logic: load a word, shift bytes out on accept, advance address
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_shreg_nxt    = r_shreg;
    w_byte_cnt_nxt = r_byte_cnt;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_addr_nxt  = '0;
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        // Bank data is only sampled here; it is static while o_busy holds the pipe
        w_shreg_nxt    = io_bus.i_rd_data;
        w_byte_cnt_nxt = '0;
        w_state_nxt    = StSend;
      end
      StSend: begin
        if (io_bus.i_tx_ready) begin
          w_shreg_nxt = r_shreg << 8;
          if (r_byte_cnt == LastByte) begin
            if (r_addr == LastAddr) begin
              w_state_nxt = StDone;
            end else begin
              w_addr_nxt  = r_addr + NB_REG'(1);
              w_state_nxt = StLoad;
            end
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + NB_CNT'(1);
          end
        end
      end
      StDone: begin
        w_addr_nxt  = '0;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs decode only from registered state and datapath
  always_comb begin
    io_bus.o_rd_addr  = r_addr;
    io_bus.o_tx_valid = (r_state == StSend);
    io_bus.o_tx_data  = (r_state == StSend) ? r_shreg[NB_DATA-1 -: 8] : 8'h00;
    o_busy            = (r_state != StIdle);
    o_done            = (r_state == StDone);
  end

endmodule

// File: tb/tb_register_dump_reader.sv
// Bench for register_dump_reader: a 32-bit/32-word instance checked every
// cycle against a token-schedule model, plus a 16-bit/8-word instance.
module tb_register_dump_reader;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic ready  = 1'b0;
  logic start2 = 1'b0;
  logic ready2 = 1'b0;
  logic busy, done, busy2, done2;

  logic [31:0] bank32 [32];
  logic [15:0] bank16 [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_dump_reader_if #(.NB_DATA(32), .NB_REG(5)) bus32 ();
  register_dump_reader_if #(.NB_DATA(16), .NB_REG(3)) bus16 ();

  assign bus32.i_rd_data  = bank32[bus32.o_rd_addr];
  assign bus32.i_tx_ready = ready;
  assign bus16.i_rd_data  = bank16[bus16.o_rd_addr];
  assign bus16.i_tx_ready = ready2;

  register_dump_reader #(.NB_DATA(32), .NB_REG(5), .N_WORDS(32)) u_dut32 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .io_bus  (bus32)
  );

  register_dump_reader #(.NB_DATA(16), .NB_REG(3), .N_WORDS(8)) u_dut16 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start2),
    .o_busy  (busy2),
    .o_done  (done2),
    .io_bus  (bus16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a dump is a schedule of tokens. A load token lasts one cycle,
  // a byte token lasts until accepted, a done token lasts one cycle.
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic [4:0] addr;
  } tok_t;
  localparam logic [1:0] TkLoad = 2'd0;
  localparam logic [1:0] TkByte = 2'd1;
  localparam logic [1:0] TkDone = 2'd2;

  tok_t mdl_q[$];
  tok_t h;
  bit   chk_en = 1'b0;

  function automatic void mdl_fill();
    for (int k = 0; k < 32; k++) begin
      mdl_q.push_back(tok_t'{TkLoad, 8'h00, 5'(k)});
      for (int b = 0; b < 4; b++)
        mdl_q.push_back(tok_t'{TkByte, bank32[k][31-8*b -: 8], 5'(k)});
    end
    mdl_q.push_back(tok_t'{TkDone, 8'h00, 5'd31});
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
      chk_en = 1'b1;
    end else if (mdl_q.size() == 0) begin
      if (start) mdl_fill();
    end else if (mdl_q[0].kind != TkByte || ready) begin
      void'(mdl_q.pop_front());
    end
  end

  // Per-cycle compare of the 32-bit instance against the model
  logic [7:0] cap[$];
  int         n_done = 0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic       e_busy, e_valid, e_done;
  logic [4:0] e_addr;
  logic [7:0] e_data;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_addr = 5'd0; e_data = 8'h00;
      if (mdl_q.size() != 0) begin
        h       = mdl_q[0];
        e_busy  = 1'b1;
        e_addr  = h.addr;
        e_valid = (h.kind == TkByte);
        e_done  = (h.kind == TkDone);
        e_data  = h.data;
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("tx_valid", 32'(bus32.o_tx_valid), 32'(e_valid));
      chk("done", 32'(done), 32'(e_done));
      chk("rd_addr", 32'(bus32.o_rd_addr), 32'(e_addr));
      if (e_valid) chk("tx_data", 32'(bus32.o_tx_data), 32'(e_data));
      if (hold_pend) begin
        chk("hold_valid", 32'(bus32.o_tx_valid), 32'd1);
        chk("hold_data", 32'(bus32.o_tx_data), 32'(hold_data));
      end
      hold_pend = (bus32.o_tx_valid === 1'b1) && !ready && !rst;
      hold_data = bus32.o_tx_data;
      if ((bus32.o_tx_valid === 1'b1) && ready && !rst) cap.push_back(bus32.o_tx_data);
      if (done === 1'b1) n_done++;
    end
  end

  // Capture and stall-stability check for the 16-bit instance
  logic [7:0] cap2[$];
  int         n_done2 = 0;
  int         cap2_at_done = -1;
  bit         hold2_pend = 1'b0;
  logic [7:0] hold2_data;

  always @(negedge clk) begin
    if (chk_en) begin
      if (hold2_pend) begin
        chk("d16_hold_valid", 32'(bus16.o_tx_valid), 32'd1);
        chk("d16_hold_data", 32'(bus16.o_tx_data), 32'(hold2_data));
      end
      hold2_pend = (bus16.o_tx_valid === 1'b1) && !ready2 && !rst;
      hold2_data = bus16.o_tx_data;
      if ((bus16.o_tx_valid === 1'b1) && ready2 && !rst) cap2.push_back(bus16.o_tx_data);
      if (done2 === 1'b1) begin
        n_done2++;
        cap2_at_done = cap2.size();
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int done_rel;
    int ndone;
    int nd0;
    int n;

    for (int k = 0; k < 32; k++) bank32[k] = {4{8'(k)}};
    bank32[1] = 32'hDEADBEEF;
    for (int k = 0; k < 8; k++) bank16[k] = 16'hA000 + 16'(k);

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus32.o_tx_valid), 32'd0);
    chk("rst_data", 32'(bus32.o_tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(bus32.o_rd_addr), 32'd0);
    chk("rst16_valid", 32'(bus16.o_tx_valid), 32'd0);
    chk("rst16_busy", 32'(busy2), 32'd0);
    step();

    // Full dump, ready tied high: exact timing and byte order
    ready = 1'b1;
    cap.delete();
    start = 1'b1; step(); start = 1'b0;
    rel = 1; done_rel = -1; ndone = 0;
    while (rel <= 165) begin
      @(negedge clk);
      if (rel == 1) begin
        chk("t1_mdl_len", 32'(mdl_q.size()), 32'd161);
        chk("t1_mdl_ad", 32'(mdl_q[7].data), 32'hAD);
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_rel < 0) done_rel = rel;
      end
      if (rel == 161) chk("t1_busy_161", 32'(busy), 32'd1);
      if (rel == 162) chk("t1_busy_162", 32'(busy), 32'd0);
      step();
      rel++;
    end
    chk("t1_done_cycle", 32'(done_rel), 32'd161);
    chk("t1_done_count", 32'(ndone), 32'd1);
    chk("t1_nbytes", 32'(cap.size()), 32'd128);
    chk("t1_b0", 32'(cap[0]), 32'h00);
    chk("t1_b3", 32'(cap[3]), 32'h00);
    chk("t1_b4", 32'(cap[4]), 32'hDE);
    chk("t1_b5", 32'(cap[5]), 32'hAD);
    chk("t1_b6", 32'(cap[6]), 32'hBE);
    chk("t1_b7", 32'(cap[7]), 32'hEF);
    chk("t1_b8", 32'(cap[8]), 32'h02);
    chk("t1_b127", 32'(cap[127]), 32'h1F);

    // Backpressure while 0xAD is on the wire
    cap.delete();
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_valid", 32'(bus32.o_tx_valid), 32'd1);
      chk("t2_data", 32'(bus32.o_tx_data), 32'hAD);
      chk("t2_addr", 32'(bus32.o_rd_addr), 32'd1);
      step();
    end
    ready = 1'b1;
    wait_idle(400, "t2_timeout");
    chk("t2_nbytes", 32'(cap.size()), 32'd128);
    chk("t2_b4", 32'(cap[4]), 32'hDE);
    chk("t2_b5", 32'(cap[5]), 32'hAD);
    chk("t2_b6", 32'(cap[6]), 32'hBE);
    chk("t2_b7", 32'(cap[7]), 32'hEF);

    // Start pulses during busy are ignored; start right after done restarts
    cap.delete();
    start = 1'b1; step(); start = 1'b0;
    rel = 1; ndone = 0;
    while (rel < 163) begin
      start = (rel == 10 || rel == 161 || rel == 162);
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (rel == 162) chk("t3_idle_162", 32'(busy), 32'd0);
      step();
      rel++;
    end
    start = 1'b0;
    @(negedge clk);
    chk("t3_busy_163", 32'(busy), 32'd1);
    chk("t3_addr_163", 32'(bus32.o_rd_addr), 32'd0);
    chk("t3_ndone", 32'(ndone), 32'd1);
    chk("t3_nbytes1", 32'(cap.size()), 32'd128);
    step();
    wait_idle(400, "t3_timeout");
    chk("t3_nbytes2", 32'(cap.size()), 32'd256);
    chk("t3_b128", 32'(cap[128]), 32'h00);
    chk("t3_b132", 32'(cap[132]), 32'hDE);

    // Reset mid word 9 during an accepted handshake
    cap.delete();
    nd0 = n_done;
    start = 1'b1; step(); start = 1'b0;
    repeat (49) step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_valid_50", 32'(bus32.o_tx_valid), 32'd1);
    chk("t4_data_50", 32'(bus32.o_tx_data), 32'h09);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_valid_51", 32'(bus32.o_tx_valid), 32'd0);
    chk("t4_busy_51", 32'(busy), 32'd0);
    chk("t4_addr_51", 32'(bus32.o_rd_addr), 32'd0);
    chk("t4_done_51", 32'(done), 32'd0);
    chk("t4_nbytes", 32'(cap.size()), 32'd39);
    step();
    repeat (8) step();
    chk("t4_no_done", 32'(n_done - nd0), 32'd0);
    cap.delete();
    start = 1'b1; step(); start = 1'b0;
    wait_idle(400, "t4_timeout");
    chk("t4_nbytes2", 32'(cap.size()), 32'd128);
    chk("t4_first", 32'(cap[0]), 32'h00);
    chk("t4_b4", 32'(cap[4]), 32'hDE);

    // Random bank image, random ready
    repeat (2) begin
      for (int k = 0; k < 32; k++) bank32[k] = $urandom();
      cap.delete();
      nd0 = n_done;
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
        ready = 1'($urandom_range(1, 0));
        step();
        n++;
      end
      ready = 1'b1;
      chk("t6_timeout", 32'(n < 2000), 32'd1);
      chk("t6_nbytes", 32'(cap.size()), 32'd128);
      for (int i = 0; i < 128 && i < cap.size(); i++)
        chk("t6_byte", 32'(cap[i]), 32'(bank32[i/4][31-8*(i%4) -: 8]));
      chk("t6_ndone", 32'(n_done - nd0), 32'd1);
    end

    // 16-bit, 8-word instance with random ready
    cap2.delete();
    nd0 = n_done2;
    start2 = 1'b1; step(); start2 = 1'b0;
    n = 0;
    while (busy2 !== 1'b0 && n < 500) begin
      ready2 = 1'($urandom_range(1, 0));
      step();
      n++;
    end
    ready2 = 1'b0;
    chk("t5_timeout", 32'(n < 500), 32'd1);
    chk("t5_nbytes", 32'(cap2.size()), 32'd16);
    for (int k = 0; k < 8 && 2*k+1 < cap2.size(); k++) begin
      chk("t5_hi", 32'(cap2[2*k]), 32'hA0);
      chk("t5_lo", 32'(cap2[2*k+1]), 32'(k));
    end
    chk("t5_ndone", 32'(n_done2 - nd0), 32'd1);
    chk("t5_done_after_last", 32'(cap2_at_done), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
